regfile_access_sequencer: RTL and testbench

- Initiator side of the 8-bit CPU register-file port; the register file is the responder.
- Accepts one decoded ALU instruction per start handshake: opcode, destination rd, sources rs1/rs2.
- Drives the two register-file read addresses and captures the operands.
- Computes the result and flags, then issues a single-cycle write-back strobe.
- Suppresses writes to the protected register (index 6), which the register file also refuses.

---
 rtl/regfile_access_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_regfile_access_sequencer.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/regfile_access_sequencer.sv
// Sequences one ALU instruction through register-file read, execute and write-back.
// Instruction flow is IDLE -> FETCH -> EXEC -> WB, one instruction per four cycles.
module regfile_access_sequencer #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 3,
  parameter logic [ADDR_W-1:0] PROTECTED_ADDR = ADDR_W'(6)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [ADDR_W-1:0] rd,
  input  logic [ADDR_W-1:0] rs1,
  input  logic [ADDR_W-1:0] rs2,
  output logic              busy,
  output logic              done,
  output logic              illegal_dest,
  output logic [DATA_W-1:0] result,
  output logic              flag_z,
  output logic              flag_c,
  output logic [ADDR_W-1:0] rf_read_addr1,
  output logic [ADDR_W-1:0] rf_read_addr2,
  input  logic [DATA_W-1:0] rf_data1,
  input  logic [DATA_W-1:0] rf_data2,
  output logic              rf_write_enable,
  output logic [ADDR_W-1:0] rf_write_addr,
  output logic [DATA_W-1:0] rf_write_data
);

  localparam int unsigned WIDE_W = DATA_W + 1;

  localparam logic [2:0] OP_MOV = 3'd0;
  localparam logic [2:0] OP_ADD = 3'd1;
  localparam logic [2:0] OP_SUB = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_OR  = 3'd4;
  localparam logic [2:0] OP_XOR = 3'd5;
  localparam logic [2:0] OP_INC = 3'd6;
  localparam logic [2:0] OP_DEC = 3'd7;

  typedef enum logic [1:0] {IDLE, FETCH, EXEC, WB} state_t;

  state_t              state_q, state_d;
  logic [2:0]          op_q, op_d;
  logic [ADDR_W-1:0]   rd_q, rd_d;
  logic [DATA_W-1:0]   opa_q, opa_d;
  logic [DATA_W-1:0]   opb_q, opb_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                illegal_q, illegal_d;
  logic [DATA_W-1:0]   result_q, result_d;
  logic                z_q, z_d;
  logic                c_q, c_d;
  logic [ADDR_W-1:0]   raddr1_q, raddr1_d;
  logic [ADDR_W-1:0]   raddr2_q, raddr2_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   waddr_q, waddr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [WIDE_W-1:0]   alu_wide;

  // Widened ALU: bit DATA_W carries the carry or borrow.
  always_comb begin
    alu_wide = '0;
    case (op_q)
      OP_MOV: alu_wide = WIDE_W'(opa_q);
      OP_ADD: alu_wide = WIDE_W'(opa_q) + WIDE_W'(opb_q);
      OP_SUB: alu_wide = WIDE_W'(opa_q) - WIDE_W'(opb_q);
      OP_AND: alu_wide = WIDE_W'(opa_q & opb_q);
      OP_OR:  alu_wide = WIDE_W'(opa_q | opb_q);
      OP_XOR: alu_wide = WIDE_W'(opa_q ^ opb_q);
      OP_INC: alu_wide = WIDE_W'(opa_q) + WIDE_W'(1);
      OP_DEC: alu_wide = WIDE_W'(opa_q) - WIDE_W'(1);
      default: alu_wide = '0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    rd_d      = rd_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    illegal_d = 1'b0;
    result_d  = result_q;
    z_d       = z_q;
    c_d       = c_q;
    raddr1_d  = '0;
    raddr2_d  = '0;
    we_d      = 1'b0;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = FETCH;
          op_d     = op;
          rd_d     = rd;
          raddr1_d = rs1;
          raddr2_d = rs2;
          busy_d   = 1'b1;
        end
      end
      FETCH: begin
        opa_d   = rf_data1;
        opb_d   = rf_data2;
        state_d = EXEC;
      end
      EXEC: begin
        result_d  = alu_wide[DATA_W-1:0];
        z_d       = (alu_wide[DATA_W-1:0] == '0);
        c_d       = alu_wide[DATA_W];
        done_d    = 1'b1;
        we_d      = (rd_q != PROTECTED_ADDR);
        illegal_d = (rd_q == PROTECTED_ADDR);
        waddr_d   = rd_q;
        wdata_d   = alu_wide[DATA_W-1:0];
        state_d   = WB;
      end
      WB: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      op_q      <= '0;
      rd_q      <= '0;
      opa_q     <= '0;
      opb_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      result_q  <= '0;
      z_q       <= 1'b0;
      c_q       <= 1'b0;
      raddr1_q  <= '0;
      raddr2_q  <= '0;
      we_q      <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      rd_q      <= rd_d;
      opa_q     <= opa_d;
      opb_q     <= opb_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      illegal_q <= illegal_d;
      result_q  <= result_d;
      z_q       <= z_d;
      c_q       <= c_d;
      raddr1_q  <= raddr1_d;
      raddr2_q  <= raddr2_d;
      we_q      <= we_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign illegal_dest  = illegal_q;
  assign result        = result_q;
  assign flag_z        = z_q;
  assign flag_c        = c_q;
  assign rf_read_addr1 = raddr1_q;
  assign rf_read_addr2 = raddr2_q;
  assign rf_write_addr = waddr_q;
  assign rf_write_data = wdata_q;
  // Reset raised during WB must kill the strobe before the register file samples it.
  assign rf_write_enable = we_q & ~reset;

endmodule

// File: tb/tb_regfile_access_sequencer.sv
// Directed bench for regfile_access_sequencer with a behavioural 8x8 register file.
module tb_regfile_access_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [2:0] op = '0, rd = '0, rs1 = '0, rs2 = '0;
  logic       busy, done, illegal_dest, flag_z, flag_c;
  logic [7:0] result, rf_data1, rf_data2, rf_write_data;
  logic [2:0] rf_read_addr1, rf_read_addr2, rf_write_addr;
  logic       rf_write_enable;

  logic [7:0] rf [8] = '{default: 8'h00};
  logic       load_en = 1'b0;
  logic [2:0] load_addr = '0;
  logic [7:0] load_data = '0;
  int         wr_strobes = 0;
  int         checks = 0;
  int         errors = 0;

  regfile_access_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .rd(rd), .rs1(rs1), .rs2(rs2),
    .busy(busy), .done(done), .illegal_dest(illegal_dest), .result(result),
    .flag_z(flag_z), .flag_c(flag_c),
    .rf_read_addr1(rf_read_addr1), .rf_read_addr2(rf_read_addr2),
    .rf_data1(rf_data1), .rf_data2(rf_data2),
    .rf_write_enable(rf_write_enable), .rf_write_addr(rf_write_addr),
    .rf_write_data(rf_write_data)
  );

  always #5 clk = ~clk;

  assign rf_data1 = rf[rf_read_addr1];
  assign rf_data2 = rf[rf_read_addr2];

  // Register file model: refuses index 6, writes on the strobe edge.
  always @(posedge clk) begin
    if (load_en) rf[load_addr] <= load_data;
    else if (rf_write_enable && rf_write_addr != 3'd6) rf[rf_write_addr] <= rf_write_data;
    if (rf_write_enable) wr_strobes <= wr_strobes + 1;
  end

  task automatic preload(input logic [2:0] a, input logic [7:0] d);
    @(negedge clk); load_en = 1'b1; load_addr = a; load_data = d;
    @(posedge clk); #1 load_en = 1'b0;
  endtask

  // Returns #1 after the accept edge (FETCH cycle).
  task automatic issue(input logic [2:0] o, input logic [2:0] d, input logic [2:0] a, input logic [2:0] b);
    @(negedge clk); op = o; rd = d; rs1 = a; rs2 = b; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic to_wb();
    @(posedge clk); @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b1; op = 3'd1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if ({busy, done, illegal_dest, flag_z, flag_c, rf_write_enable} !== 6'b0) begin errors++; $display("FAIL reset_ctrl got %b want 000000", {busy, done, illegal_dest, flag_z, flag_c, rf_write_enable}); end
    checks++; if ({result, rf_write_data} !== 16'h0) begin errors++; $display("FAIL reset_data got %h want 0000", {result, rf_write_data}); end
    checks++; if ({rf_read_addr1, rf_read_addr2, rf_write_addr} !== 9'h0) begin errors++; $display("FAIL reset_addr got %h want 000", {rf_read_addr1, rf_read_addr2, rf_write_addr}); end
    @(negedge clk); reset = 1'b0; start = 1'b0;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_start_dropped busy got %b want 0", busy); end
  endtask

  task automatic test_add();
    preload(3'd0, 8'hF0); preload(3'd1, 8'h20);
    issue(3'd1, 3'd2, 3'd0, 3'd1);
    checks++; if ({busy, done} !== 2'b10) begin errors++; $display("FAIL add_fetch busy/done got %b want 10", {busy, done}); end
    checks++; if ({rf_read_addr1, rf_read_addr2} !== {3'd0, 3'd1}) begin errors++; $display("FAIL add_fetch_addr got %h want 01", {rf_read_addr1, rf_read_addr2}); end
    @(posedge clk); #1;
    checks++; if ({done, rf_write_enable} !== 2'b00) begin errors++; $display("FAIL add_exec done/we got %b want 00", {done, rf_write_enable}); end
    @(posedge clk); #1;
    checks++; if ({done, rf_write_enable, illegal_dest, busy} !== 4'b1101) begin errors++; $display("FAIL add_wb_ctrl got %b want 1101", {done, rf_write_enable, illegal_dest, busy}); end
    checks++; if ({rf_write_addr, rf_write_data, result} !== {3'd2, 8'h10, 8'h10}) begin errors++; $display("FAIL add_wb_data got %h/%h/%h want 2/10/10", rf_write_addr, rf_write_data, result); end
    checks++; if ({flag_c, flag_z} !== 2'b10) begin errors++; $display("FAIL add_flags got %b want 10", {flag_c, flag_z}); end
    @(posedge clk); #1;
    checks++; if ({done, rf_write_enable, busy} !== 3'b000) begin errors++; $display("FAIL add_idle got %b want 000", {done, rf_write_enable, busy}); end
    checks++; if (rf[2] !== 8'h10) begin errors++; $display("FAIL add_rf_written got %h want 10", rf[2]); end
  endtask

  task automatic test_sub();
    preload(3'd3, 8'h05); preload(3'd4, 8'h05);
    issue(3'd2, 3'd1, 3'd3, 3'd4); to_wb();
    checks++; if ({result, flag_z, flag_c} !== {8'h00, 1'b1, 1'b0}) begin errors++; $display("FAIL sub_zero got %h z%b c%b want 00 z1 c0", result, flag_z, flag_c); end
    @(posedge clk);
    preload(3'd3, 8'h03); preload(3'd4, 8'h04);
    issue(3'd2, 3'd1, 3'd3, 3'd4); to_wb();
    checks++; if ({result, flag_z, flag_c} !== {8'hFF, 1'b0, 1'b1}) begin errors++; $display("FAIL sub_borrow got %h z%b c%b want ff z0 c1", result, flag_z, flag_c); end
    @(posedge clk);
  endtask

  task automatic test_inc_dec();
    preload(3'd5, 8'hFF);
    issue(3'd6, 3'd0, 3'd5, 3'd3); to_wb();
    checks++; if ({result, flag_z, flag_c} !== {8'h00, 1'b1, 1'b1}) begin errors++; $display("FAIL inc_wrap got %h z%b c%b want 00 z1 c1", result, flag_z, flag_c); end
    @(posedge clk);
    preload(3'd7, 8'h00);
    issue(3'd7, 3'd1, 3'd7, 3'd5); to_wb();
    checks++; if ({result, flag_z, flag_c} !== {8'hFF, 1'b0, 1'b1}) begin errors++; $display("FAIL dec_wrap got %h z%b c%b want ff z0 c1", result, flag_z, flag_c); end
    @(posedge clk);
  endtask

  task automatic test_logic();
    preload(3'd0, 8'hF0); preload(3'd1, 8'h3C);
    issue(3'd3, 3'd3, 3'd0, 3'd1); to_wb();
    checks++; if ({result, flag_c} !== {8'h30, 1'b0}) begin errors++; $display("FAIL and got %h c%b want 30 c0", result, flag_c); end
    @(posedge clk);
    issue(3'd4, 3'd4, 3'd0, 3'd1); to_wb();
    checks++; if (result !== 8'hFC) begin errors++; $display("FAIL or got %h want fc", result); end
    @(posedge clk);
    issue(3'd5, 3'd5, 3'd0, 3'd1); to_wb();
    checks++; if (result !== 8'hCC) begin errors++; $display("FAIL xor got %h want cc", result); end
    @(posedge clk);
  endtask

  task automatic test_protected();
    int w0;
    logic we_seen;
    preload(3'd3, 8'hA5);
    w0 = wr_strobes;
    issue(3'd0, 3'd6, 3'd3, 3'd2);
    we_seen = rf_write_enable;
    @(posedge clk); #1 we_seen = we_seen | rf_write_enable;
    @(posedge clk); #1 we_seen = we_seen | rf_write_enable;
    checks++; if ({done, illegal_dest} !== 2'b11) begin errors++; $display("FAIL prot_wb done/illegal got %b want 11", {done, illegal_dest}); end
    checks++; if ({result, rf_write_addr, flag_c} !== {8'hA5, 3'd6, 1'b0}) begin errors++; $display("FAIL prot_result got %h addr %h c%b want a5 6 c0", result, rf_write_addr, flag_c); end
    @(posedge clk); #1 we_seen = we_seen | rf_write_enable;
    checks++; if (we_seen !== 1'b0) begin errors++; $display("FAIL prot_we got %b want 0", we_seen); end
    checks++; if (wr_strobes !== w0) begin errors++; $display("FAIL prot_strobes got %0d want %0d", wr_strobes, w0); end
    checks++; if (illegal_dest !== 1'b0) begin errors++; $display("FAIL prot_illegal_pulse got %b want 0", illegal_dest); end
  endtask

  task automatic test_back_to_back();
    int ndone = 0;
    preload(3'd2, 8'h40);
    @(negedge clk); op = 3'd6; rd = 3'd2; rs1 = 3'd2; rs2 = 3'd0; start = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done) ndone++;
      checks++; if (done !== ((i % 4) == 2)) begin errors++; $display("FAIL b2b_done[%0d] got %b want %b", i, done, (i % 4) == 2); end
      checks++; if (busy !== ((i % 4) != 3)) begin errors++; $display("FAIL b2b_busy[%0d] got %b want %b", i, busy, (i % 4) != 3); end
    end
    start = 1'b0;
    checks++; if (ndone !== 3) begin errors++; $display("FAIL b2b_count got %0d want 3", ndone); end
    checks++; if ({rf[2], result} !== {8'h43, 8'h43}) begin errors++; $display("FAIL b2b_hazard got rf %h result %h want 43 43", rf[2], result); end
  endtask

  task automatic test_reset_mid();
    int w0;
    preload(3'd0, 8'h11); preload(3'd1, 8'h22); preload(3'd7, 8'h00);
    w0 = wr_strobes;
    issue(3'd1, 3'd7, 3'd0, 3'd1);
    @(posedge clk);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    checks++; if ({busy, done, rf_write_enable, result} !== 11'h0) begin errors++; $display("FAIL rst_exec got busy%b done%b we%b res %h want all 0", busy, done, rf_write_enable, result); end
    @(negedge clk); reset = 1'b0;
    issue(3'd1, 3'd7, 3'd0, 3'd1); to_wb();
    checks++; if ({done, result} !== {1'b1, 8'h33}) begin errors++; $display("FAIL rst_wb_reached got done%b res %h want done1 33", done, result); end
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    checks++; if ({busy, done, rf_write_enable, result} !== 11'h0) begin errors++; $display("FAIL rst_wb got busy%b done%b we%b res %h want all 0", busy, done, rf_write_enable, result); end
    checks++; if ({wr_strobes == w0, rf[7]} !== {1'b1, 8'h00}) begin errors++; $display("FAIL rst_no_write got strobes %0d rf7 %h want %0d 00", wr_strobes, rf[7], w0); end
    @(negedge clk); reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_inc_dec();
    test_logic();
    test_protected();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
